multdiv_issue: RTL and testbench
================================

# multdiv_issue

Pipeline-side initiator for the multicycle multiply/divide units. Latches a MULT/DIV request from the execute stage and holds the operands stable. Clears and starts the selected unit, stalls the pipeline while the unit iterates, and captures `data_result`/`data_exception` on `data_resultRDY`. It then presents a one-cycle writeback with destination tag, and a watchdog converts a hung unit into an exception.

## Interface
- `MAX_CYCLES`, 40: WAIT-state cycles allowed before watchdog timeout; must be ≥ 34.
- `CNT_W`, 6: watchdog counter width; 2^CNT_W > MAX_CYCLES.

- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-low reset
- `ctrl_MULT`  in  1  multiply request, sampled in IDLE/DONE
- `ctrl_DIV`  in  1  divide request, sampled in IDLE/DONE
- `req_operandA`  in  32  operand A / dividend
- `req_operandB`  in  32  operand B / divisor
- `req_tag`  in  5  destination register
- `flush`  in  1  abort in-flight operation
- `unit_operandA`  out  32  latched operand A to unit
- `unit_operandB`  out  32  latched operand B to unit
- `unit_sel_div`  out  1  1 = divider selected, 0 = multiplier
- `unit_clear`  out  1  active-high clear/start to unit
- `unit_result`  in  32  selected unit's `data_result`
- `unit_resultRDY`  in  1  selected unit's `data_resultRDY`
- `unit_exception`  in  1  selected unit's `data_exception`
- `stall`  out  1  hold pipeline
- `wb_valid`  out  1  one-cycle writeback strobe
- `wb_data`  out  32  captured result
- `wb_tag`  out  5  captured destination
- `wb_exception`  out  1  unit exception or timeout
- `wb_timeout`  out  1  exception caused by watchdog

## Operation
- States: IDLE, CLEAR, WAIT, DONE (2-bit register).
- IDLE:
  - Request present and `flush`=0: latch operands, tag and op, then go to CLEAR.
  - `ctrl_DIV` and `ctrl_MULT` both high: DIV wins.
  - `flush`=1 drops the request.
- CLEAR: `unit_clear`=1 for exactly one cycle; watchdog counter is zeroed; next state is WAIT.
- WAIT:
  - Watchdog increments each cycle.
  - `unit_resultRDY`=1: capture `unit_result` into `wb_data` and `unit_exception` into `wb_exception`; `wb_timeout`=0; go to DONE.
  - Otherwise, if counter = MAX_CYCLES−1: capture `wb_data`=0, `wb_exception`=1, `wb_timeout`=1; go to DONE.
  - RDY wins if coincident with timeout.
- DONE: `wb_valid`=1.
  - A new non-flushed request goes directly to CLEAR (back-to-back); otherwise go to IDLE.
- `flush` in CLEAR or WAIT: go to IDLE next cycle. No `wb_valid`, capture registers unchanged.
- `flush` in DONE does not suppress `wb_valid`, because writeback is already committed.
- Requests in CLEAR/WAIT are ignored; the pipeline is stalled.
- `unit_operandA`, `unit_operandB` and `unit_sel_div` change only on request latch and are held constant through CLEAR and WAIT.
- `wb_data`, `wb_tag`, `wb_exception` and `wb_timeout` hold their value until the next capture.
- `unit_clear` = (~`rst`) | (state == CLEAR). The unit is held cleared during reset.
- No arithmetic in this block; the result passes through unmodified.

## Timing
- Reset (`rst`=0 at an edge): state IDLE; counter 0.
  - Outputs 0: `stall`, `wb_valid`, `wb_data`, `wb_tag`, `wb_exception`, `wb_timeout`, `unit_operandA`, `unit_operandB`, `unit_sel_div`.
  - `unit_clear`=1 while `rst`=0.
  - Reset mid-operation aborts with no writeback.
- `stall` is registered: 1 in CLEAR and WAIT, 0 in IDLE and DONE.
- Cycle numbering: request sampled in cycle 0 → CLEAR in cycle 1 → WAIT from cycle 2.
- RDY seen in WAIT cycle k (k=0 at cycle 2) → `wb_valid` in cycle 3+k.
- Divider: RDY at WAIT cycle 32 → `wb_valid` in cycle 35.
- Divide-by-zero: exception/RDY at WAIT cycle 0 → `wb_valid` in cycle 3.
- RDY/exception during CLEAR is ignored.
- Timeout: `wb_valid` in cycle 2+MAX_CYCLES, i.e. 42 at default.
- Flush seen in cycle n → IDLE and `stall`=0 in cycle n+1.

## Test plan
- DIV, A=100, B=7, tag=5, divider model → `stall`=1 in cycles 1–34; `wb_valid` only in cycle 35; `wb_data`=14, `wb_tag`=5, `wb_exception`=0.
- DIV, A=−100, B=7 → `wb_data`=0xFFFFFFF2; MULT, A=6, B=−3 with multiplier stub → `wb_data`=0xFFFFFFEE, `unit_sel_div`=0.
- DIV, B=0 → `wb_valid` in cycle 3, `wb_data`=0, `wb_exception`=1, `wb_timeout`=0.
- Stub with RDY tied 0 → `wb_valid` in cycle 42, `wb_exception`=1, `wb_timeout`=1, `wb_data`=0.
- Flush in cycle 10 of a DIV → `stall`=0 in cycle 11; no `wb_valid` ever; prior `wb_data` unchanged.
- Both ctrl bits high with a new request in DONE; `rst`=0 asserted in cycle 20 of another op.
  - Divider is selected; the second op's CLEAR immediately follows DONE.
  - The reset op produces no writeback and all outputs go to 0 next cycle.

Source files
------------

// File: rtl/multdiv_issue.sv
// multdiv_issue: pipeline-side initiator for the multicycle multiply/divide
// units. It latches one request and holds the operands stable. It clears and
// starts the selected unit, stalls the pipeline while the unit iterates, and
// captures the unit's result or a watchdog timeout. The outcome is then
// presented as a one-cycle writeback.
module multdiv_issue #(
    parameter int MAX_CYCLES = 40,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] req_operandA,
    input  logic [31:0] req_operandB,
    input  logic [4:0]  req_tag,
    input  logic        flush,
    output logic [31:0] unit_operandA,
    output logic [31:0] unit_operandB,
    output logic        unit_sel_div,
    output logic        unit_clear,
    input  logic [31:0] unit_result,
    input  logic        unit_resultRDY,
    input  logic        unit_exception,
    output logic        stall,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_tag,
    output logic        wb_exception,
    output logic        wb_timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Last WAIT count before the watchdog declares the unit hung.
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(MAX_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wdog_cnt;
    logic [4:0]       tag_q;
    logic             req_ok;
    logic             req_take;
    logic             rdy_take;
    logic             tmo_take;

    // A request counts only when it is not being flushed in the same cycle.
    assign req_ok = (ctrl_MULT | ctrl_DIV) & ~flush;

    // The unit is held cleared during reset as well as in the CLEAR state.
    assign unit_clear = ~rst | (state == S_CLEAR);

    // Next-state logic and the single-cycle latch/capture strobes.
    always_comb begin
        state_nxt = state;
        req_take  = 1'b0;
        rdy_take  = 1'b0;
        tmo_take  = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_ok) begin
                    req_take  = 1'b1;
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                // RDY from the unit here is stale and is deliberately ignored.
                state_nxt = flush ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (flush) begin
                    state_nxt = S_IDLE;
                end else if (unit_resultRDY) begin
                    rdy_take  = 1'b1;
                    state_nxt = S_DONE;
                end else if (wdog_cnt == WDOG_LAST) begin
                    tmo_take  = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // Writeback is already committed; flush only blocks a new request.
                if (req_ok) begin
                    req_take  = 1'b1;
                    state_nxt = S_CLEAR;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control: state, registered stall/writeback strobe and the watchdog counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            stall    <= 1'b0;
            wb_valid <= 1'b0;
            wdog_cnt <= '0;
        end else begin
            state    <= state_nxt;
            stall    <= (state_nxt == S_CLEAR) || (state_nxt == S_WAIT);
            wb_valid <= (state_nxt == S_DONE);
            if (state == S_CLEAR) begin
                wdog_cnt <= '0;
            end else if (state == S_WAIT) begin
                wdog_cnt <= wdog_cnt + CNT_W'(1);
            end
        end
    end

    // Data: the operand/tag latch on request, and the result capture on completion.
    always_ff @(posedge clk) begin
        if (!rst) begin
            unit_operandA <= '0;
            unit_operandB <= '0;
            unit_sel_div  <= 1'b0;
            tag_q         <= '0;
            wb_data       <= '0;
            wb_tag        <= '0;
            wb_exception  <= 1'b0;
            wb_timeout    <= 1'b0;
        end else begin
            if (req_take) begin
                unit_operandA <= req_operandA;
                unit_operandB <= req_operandB;
                unit_sel_div  <= ctrl_DIV;
                tag_q         <= req_tag;
            end
            if (rdy_take) begin
                wb_data      <= unit_result;
                wb_tag       <= tag_q;
                wb_exception <= unit_exception;
                wb_timeout   <= 1'b0;
            end else if (tmo_take) begin
                wb_data      <= '0;
                wb_tag       <= tag_q;
                wb_exception <= 1'b1;
                wb_timeout   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_issue.sv
// tb_multdiv_issue: directed bench for multdiv_issue with a behavioural
// multiply/divide unit model and hand-computed expected values.
module tb_multdiv_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] req_operandA;
    logic [31:0] req_operandB;
    logic [4:0]  req_tag;
    logic        flush;
    logic [31:0] unit_operandA;
    logic [31:0] unit_operandB;
    logic        unit_sel_div;
    logic        unit_clear;
    logic [31:0] unit_result;
    logic        unit_resultRDY;
    logic        unit_exception;
    logic        stall;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_tag;
    logic        wb_exception;
    logic        wb_timeout;

    int checks = 0;
    int errors = 0;

    // unit model state
    logic hang = 1'b0;
    int   ucnt = 0;

    // results of the last run_op
    int          v_cyc, v_cnt, st_first, st_last, cl_cnt;
    logic [31:0] cap_data, cap_opb;
    logic [4:0]  cap_tag;
    logic        cap_exc, cap_tmo, cap_sel;

    multdiv_issue dut (
        .clk(clk), .rst(rst), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .req_operandA(req_operandA), .req_operandB(req_operandB), .req_tag(req_tag),
        .flush(flush), .unit_operandA(unit_operandA), .unit_operandB(unit_operandB),
        .unit_sel_div(unit_sel_div), .unit_clear(unit_clear), .unit_result(unit_result),
        .unit_resultRDY(unit_resultRDY), .unit_exception(unit_exception), .stall(stall),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_tag(wb_tag),
        .wb_exception(wb_exception), .wb_timeout(wb_timeout)
    );

    always #5 clk = ~clk;

    // Unit iteration counter: zero in the first cycle after clear.
    always @(posedge clk) begin
        if (unit_clear) ucnt <= 0;
        else if (ucnt < 1000) ucnt <= ucnt + 1;
    end

    // Unit model: divider ready after 32 iterations (immediately with exception on
    // divide-by-zero, also asserted during clear), multiplier ready after 3.
    always_comb begin
        unit_resultRDY = 1'b0;
        unit_result    = 32'd0;
        unit_exception = 1'b0;
        if (!hang) begin
            if (unit_sel_div) begin
                if (unit_operandB == 32'd0) begin
                    if (unit_clear || ucnt == 0) begin
                        unit_resultRDY = 1'b1;
                        unit_exception = 1'b1;
                    end
                end else if (ucnt == 32) begin
                    unit_resultRDY = 1'b1;
                    unit_result    = 32'($signed(unit_operandA) / $signed(unit_operandB));
                end
            end else if (ucnt == 3) begin
                unit_resultRDY = 1'b1;
                unit_result    = unit_operandA * unit_operandB;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request in cycle 0 and observe cycles 1..ncyc; flush in cycle fcyc.
    task automatic run_op(input logic mult, input logic div, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag,
                          input int fcyc, input int ncyc);
        @(negedge clk);
        ctrl_MULT = mult; ctrl_DIV = div;
        req_operandA = a; req_operandB = b; req_tag = tag;
        v_cyc = -1; v_cnt = 0; st_first = -1; st_last = -1; cl_cnt = 0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
            flush = (c == fcyc);
            if (stall) begin
                if (st_first < 0) st_first = c;
                st_last = c;
            end
            if (unit_clear) cl_cnt++;
            if (c == 2) begin
                cap_sel = unit_sel_div;
                cap_opb = unit_operandB;
            end
            if (wb_valid) begin
                v_cnt++;
                if (v_cyc < 0) begin
                    v_cyc = c; cap_data = wb_data; cap_tag = wb_tag;
                    cap_exc = wb_exception; cap_tmo = wb_timeout;
                end
            end
        end
        flush = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        int vcount;
        rst = 1'b0; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; flush = 1'b0;
        req_operandA = '0; req_operandB = '0; req_tag = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_tag", 32'(wb_tag), 0);
        chk("rst_wb_exc", 32'({wb_exception, wb_timeout}), 0);
        chk("rst_opA", unit_operandA, 0);
        chk("rst_sel", 32'(unit_sel_div), 0);
        chk("rst_clear", 32'(unit_clear), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_clear", 32'(unit_clear), 0);

        // DIV 100 / 7
        run_op(1'b0, 1'b1, 32'd100, 32'd7, 5'd5, 0, 40);
        chk("div_stall_first", 32'(st_first), 1);
        chk("div_stall_last", 32'(st_last), 34);
        chk("div_valid_cyc", 32'(v_cyc), 35);
        chk("div_valid_cnt", 32'(v_cnt), 1);
        chk("div_clear_cnt", 32'(cl_cnt), 1);
        chk("div_sel", 32'(cap_sel), 1);
        chk("div_data", cap_data, 32'd14);
        chk("div_tag", 32'(cap_tag), 5);
        chk("div_exc", 32'({cap_exc, cap_tmo}), 0);

        // DIV -100 / 7
        run_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, 5'd3, 0, 40);
        chk("sdiv_valid_cyc", 32'(v_cyc), 35);
        chk("sdiv_data", cap_data, 32'hFFFF_FFF2);
        chk("sdiv_tag", 32'(cap_tag), 3);

        // MULT 6 * -3
        run_op(1'b1, 1'b0, 32'd6, 32'hFFFF_FFFD, 5'd9, 0, 10);
        chk("mul_sel", 32'(cap_sel), 0);
        chk("mul_opB", cap_opb, 32'hFFFF_FFFD);
        chk("mul_valid_cyc", 32'(v_cyc), 6);
        chk("mul_data", cap_data, 32'hFFFF_FFEE);
        chk("mul_tag", 32'(cap_tag), 9);

        // Flush in cycle 10 of a DIV
        run_op(1'b0, 1'b1, 32'd100, 32'd7, 5'd12, 10, 40);
        chk("flush_stall_last", 32'(st_last), 10);
        chk("flush_valid_cnt", 32'(v_cnt), 0);
        chk("flush_data_kept", wb_data, 32'hFFFF_FFEE);
        chk("flush_tag_kept", 32'(wb_tag), 9);

        // Hung unit -> watchdog timeout
        hang = 1'b1;
        run_op(1'b0, 1'b1, 32'd50, 32'd5, 5'd17, 0, 45);
        hang = 1'b0;
        chk("tmo_valid_cyc", 32'(v_cyc), 42);
        chk("tmo_valid_cnt", 32'(v_cnt), 1);
        chk("tmo_data", cap_data, 0);
        chk("tmo_flags", 32'({cap_exc, cap_tmo}), 32'b11);
        chk("tmo_tag", 32'(cap_tag), 17);

        // Divide by zero: RDY during CLEAR ignored, captured in first WAIT cycle
        run_op(1'b0, 1'b1, 32'd100, 32'd0, 5'd2, 0, 6);
        chk("dz_valid_cyc", 32'(v_cyc), 3);
        chk("dz_data", cap_data, 0);
        chk("dz_flags", 32'({cap_exc, cap_tmo}), 32'b10);

        // Back-to-back: new request (both ctrl bits) in DONE
        run_op(1'b1, 1'b0, 32'd2, 32'd3, 5'd1, 0, 5);
        @(negedge clk);
        chk("b2b_done_valid", 32'(wb_valid), 1);
        chk("b2b_done_data", wb_data, 32'd6);
        ctrl_MULT = 1'b1; ctrl_DIV = 1'b1;
        req_operandA = 32'd100; req_operandB = 32'd7; req_tag = 5'd7;
        @(negedge clk);
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        chk("b2b_clear", 32'(unit_clear), 1);
        chk("b2b_stall", 32'(stall), 1);
        chk("b2b_sel_div", 32'(unit_sel_div), 1);
        chk("b2b_opA", unit_operandA, 32'd100);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (wb_valid && n < 0) n = i;
        end
        chk("b2b_latency", 32'(n), 34);
        chk("b2b_data", wb_data, 32'd14);
        chk("b2b_tag", 32'(wb_tag), 7);

        // Reset in cycle 20 of another op
        @(negedge clk);
        ctrl_DIV = 1'b1; req_operandA = 32'd77; req_operandB = 32'd7; req_tag = 5'd4;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            ctrl_DIV = 1'b0;
        end
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_stall", 32'(stall), 0);
        chk("mrst_wb_valid", 32'(wb_valid), 0);
        chk("mrst_wb_data", wb_data, 0);
        chk("mrst_wb_tag", 32'(wb_tag), 0);
        chk("mrst_opA", unit_operandA, 0);
        chk("mrst_sel", 32'(unit_sel_div), 0);
        chk("mrst_clear", 32'(unit_clear), 1);
        rst = 1'b1;
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wb_valid) vcount++;
        end
        chk("mrst_no_wb", 32'(vcount), 0);
        chk("mrst_idle_stall", 32'(stall), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
